// File: rtl/yport_pkg.sv
// yport_pkg: definitions shared by the Y-port receiver and the write buffer.
//   DEPTH_DEFAULT - default FIFO depth (a power of two, at least 2)
//   state_t       - handshake FSM states
//   parity_ok()   - parity check used on both sides of the link
package yport_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  // The check passes when the XOR of every data bit and the parity bit equals
  // the parity mode: 0 selects even parity, 1 selects odd parity.
  function automatic logic parity_ok(input logic [31:0] data,
                                     input logic        par,
                                     input logic        sel);
    return ((^data) ^ par) == sel;
  endfunction

endpackage

// File: rtl/yport_fifo.sv
// yport_fifo: synchronous FIFO that holds accepted Y-port words.
//   clk, rst  - clock; asynchronous active-low reset (clears pointers and count)
//   push      - write wdata; ignored when full
//   pop       - drop the head word; ignored when empty
//   wdata     - word to write
//   rdata     - head word, or 0 when empty
//   full      - occupancy equals DEPTH
//   empty     - occupancy is 0
//   level     - occupancy, 0..DEPTH
module yport_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_L);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked solely by the
  // reset pointers and count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yport_receiver.sv
// yport_receiver: receives 32-bit words from a write buffer over a 4-phase
// YREQ/YACK handshake, checks their parity and queues good words in a FIFO.
//   clk, rst        - clock; asynchronous active-low reset
//   YREQ            - request; YDATA/YPARITY are valid while it is high
//   YDATA, YPARITY  - word and its parity bit
//   PARITYSEL       - parity mode (0 even, 1 odd)
//   YACK            - registered acknowledge, high only in ACK
//   out_valid       - FIFO head word available
//   out_ready       - consumer accepts the head word
//   out_data        - FIFO head word (0 when empty)
//   level           - FIFO occupancy
//   par_err         - sticky parity-error flag
//   err_count       - saturating count of parity-failed words
//   err_clr         - synchronous clear of par_err/err_count (wins over a new error)
module yport_receiver
  import yport_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   YREQ,
  input  logic [31:0]            YDATA,
  input  logic                   YPARITY,
  input  logic                   PARITYSEL,
  output logic                   YACK,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   par_err,
  output logic [7:0]             err_count,
  input  logic                   err_clr
);

  state_t state;
  state_t next_state;
  logic   sample;
  logic   parity_pass;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  logic   err_event;
  logic   yack_q;

  assign parity_pass = parity_ok(YDATA, YPARITY, PARITYSEL);
  assign push        = sample && parity_pass;
  assign err_event   = sample && !parity_pass;
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;
  assign YACK        = yack_q;

  // Fullness is the registered occupancy: a pop on the same edge does not
  // open a slot for a push until the following cycle.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (YREQ) begin
          if (!full) begin
            sample     = 1'b1;
            next_state = ACK;
          end else begin
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (!YREQ) begin
          next_state = IDLE;
        end else if (!full) begin
          sample     = 1'b1;
          next_state = ACK;
        end
      end
      ACK: begin
        if (!YREQ) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // YACK has its own flop so the write buffer sees a glitch-free level.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      yack_q <= 1'b0;
    end else begin
      state  <= next_state;
      yack_q <= (next_state == ACK);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err   <= 1'b0;
      err_count <= 8'd0;
    end else if (err_clr) begin
      par_err   <= 1'b0;
      err_count <= 8'd0;
    end else if (err_event) begin
      par_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  yport_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (YDATA),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: doc/yport_receiver.md
YPORT_RECEIVER -- requirements
Module: yport_receiver

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: YREQ  input  1  write-buffer request; YDATA/YPARITY valid while high.
REQ-004 SHALL have port: YDATA  input  32  word from write buffer.
REQ-005 SHALL have port: YPARITY  input  1  parity bit accompanying YDATA.
REQ-006 SHALL have port: PARITYSEL  input  1  parity mode; 0 even, 1 odd; same signal fed to write buffer.
REQ-007 SHALL have port: YACK  output  1  acknowledge to write buffer (4-phase).
REQ-008 SHALL have port: out_valid  output  1  FIFO head word available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts head word.
REQ-010 SHALL have port: out_data  output  32  FIFO head word.
REQ-011 SHALL have port: level  output  3  FIFO occupancy, 0..4.
REQ-012 SHALL have port: par_err  output  1  sticky parity-error flag.
REQ-013 SHALL have port: err_count  output  8  saturating count of parity-failed words.
REQ-014 SHALL have port: err_clr  input  1  synchronous clear of par_err and err_count.
REQ-015 SHALL use parameter: DEPTH, default 4, FIFO entries; power of two.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD, ACK; YACK a registered output, high only in ACK.
REQ-017 Parity check SHALL pass when XOR of YDATA[31:0] and YPARITY equals PARITYSEL.
REQ-018 IDLE, YREQ=1, level<DEPTH: SHALL sample YDATA/YPARITY that edge, push word if parity passes, go to ACK; YACK high next cycle (1-cycle latency).
REQ-019 IDLE, YREQ=1, level==DEPTH: SHALL go to HOLD with YACK=0; no word sampled.
REQ-020 HOLD: SHALL sample/push and go to ACK on first edge with level<DEPTH; SHALL return to IDLE if YREQ drops first.
REQ-021 Full is judged on registered level; a pop in the same cycle SHALL NOT permit a push that cycle.
REQ-022 ACK: SHALL hold YACK=1 until YREQ sampled 0, then go to IDLE with YACK=0 next cycle; no new sample until IDLE sees YREQ=1 again.
REQ-023 Parity-failed word SHALL be acknowledged normally, discarded, par_err set, err_count incremented, saturating at 255.
REQ-024 Parity check on a full FIFO SHALL be deferred to the HOLD exit sample.
REQ-025 Pop SHALL occur on out_valid && out_ready; out_data SHALL show the head word, X-free (0) when empty.
REQ-026 Pushed word SHALL appear on out_valid the cycle after push; no bypass.
REQ-027 Simultaneous push and pop with 0<level<DEPTH: level unchanged, order preserved.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; level SHALL be 0..DEPTH.
REQ-029 err_clr SHALL take priority over a same-cycle error increment, with the result 0/0.

Reset
REQ-030 rst low SHALL immediately force FSM to IDLE, YACK=0, out_valid=0, out_data=0, level=0, par_err=0, err_count=0.
REQ-031 Reset mid-handshake SHALL drop YACK asynchronously and discard FIFO contents; after release, YREQ still high SHALL be treated as a new request.
REQ-032 FIFO storage array SHALL need no reset; only pointers/count are reset.

Structure
REQ-033 Package yport_pkg SHALL hold DEPTH default, the FSM state enum, and a parity-check function shared with the write buffer.
REQ-034 FIFO SHALL be sub-module yport_fifo (push/pop/full/empty/level); FSM and error logic in yport_receiver.

Verification
REQ-035 PARITYSEL=0, YDATA=32'h0000_0003, YPARITY=0, YREQ high -> YACK high 1 cycle later, out_valid next cycle, out_data=32'h3.
REQ-036 PARITYSEL=1, YDATA=32'h0000_0001, YPARITY=1 -> YACK completes, no push, par_err=1, err_count=1, level=0.
REQ-037 Five valid words, out_ready=0 -> first four acked, fifth held in HOLD with YACK=0; one pop -> fifth acked next handshake, level=4.
REQ-038 Write 8 words with out_ready=1 throughout -> output order equals input order across pointer wrap.
REQ-039 rst low while YACK=1, level=2 -> YACK=0, level=0, out_valid=0 same cycle; after release, YREQ=1 is accepted afresh.
REQ-040 Force 256 parity errors -> err_count=255; err_clr with simultaneous error -> err_count=0, par_err=0.
